fifo_wr_arbiter: RTL

- Round-robin arbiter that shares the single write port of the asynchronous FIFO (WR_DATA/W_INC/FULL) between N_REQ write-domain requesters.
- Sits entirely in the FIFO write clock domain, between the requesters (register file, ALU result path, config path) and the FIFO.
- Holds one registered beat and gates W_INC with FULL so that no beat is lost or duplicated.

---
 rtl/fifo_arb_pkg.sv | 21 ++
 rtl/rr_priority_pick.sv | 34 +++
 rtl/fifo_wr_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// fifo_arb_pkg: shared defaults and helpers for the
// FIFO write-port arbiters.
package fifo_arb_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_N_REQ      = 4;
  localparam int DEF_MAX_BURST  = 4;

  // Ceiling log2, with a minimum of one bit for v = 2.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int DEF_SEL_W = clog2(DEF_N_REQ);

endpackage

// File: rtl/rr_priority_pick.sv
// rr_priority_pick: rotate-search from ptr, returns the
// first set request as one-hot and binary index.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  int j;

  // Walk offsets high to low so the nearest request at or above ptr wins.
  always_comb begin
    gnt = '0;
    idx = '0;
    j   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= N) j = j - N;
      if (req[j]) begin
        gnt    = '0;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin share of one async-FIFO write port.
// Optional owner bursts enabled with macro ARB_BURST_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int N_REQ      = DEF_N_REQ,
  parameter int ID_WIDTH   = clog2(N_REQ),
  parameter int MAX_BURST  = DEF_MAX_BURST
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [N_REQ-1:0]            REQ,
  input  logic [N_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [N_REQ-1:0]            GNT,
  input  logic                        FULL,
  output logic                        W_INC,
  output logic [DATA_WIDTH-1:0]       WR_DATA,
  output logic [ID_WIDTH-1:0]         OWNER,
  output logic                        BUSY
);

  if (N_REQ < 2 || N_REQ > 8 || ID_WIDTH != clog2(N_REQ) ||
      MAX_BURST < 1) begin : g_bad_cfg
    $error("fifo_wr_arbiter: illegal parameter set");
  end

  logic                  hold_vld;
  logic [DATA_WIDTH-1:0] hold_data;
  logic [ID_WIDTH-1:0]   owner_q;
  logic [ID_WIDTH-1:0]   ptr_q;
  logic [N_REQ-1:0]      pick_gnt;
  logic [ID_WIDTH-1:0]   pick_idx;
  logic                  pick_any;
  logic                  load;
  logic [ID_WIDTH-1:0]   idx_inc;
  logic [DATA_WIDTH-1:0] slice [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_slice
    assign slice[i] = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_priority_pick #(
    .N  (N_REQ),
    .IW (ID_WIDTH)
  ) u_pick (
    .req (REQ),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign W_INC   = hold_vld & ~FULL;
  assign load    = ~RST & (~hold_vld | W_INC) & pick_any;
  assign GNT     = load ? pick_gnt : '0;
  assign WR_DATA = hold_data;
  assign OWNER   = owner_q;
  assign BUSY    = hold_vld;

  assign idx_inc = (pick_idx == ID_WIDTH'(N_REQ - 1)) ?
                   '0 : pick_idx + ID_WIDTH'(1);

`ifdef ARB_BURST_EN
  localparam int BW = clog2(MAX_BURST + 1);

  logic [BW-1:0]       burst_cnt;
  logic [BW-1:0]       cnt_nxt;
  logic                same_owner;
  logic [ID_WIDTH-1:0] owner_inc;

  // burst_cnt holds beats already granted in the running burst.
  assign same_owner = (pick_idx == owner_q) && (burst_cnt != '0);
  assign cnt_nxt    = (same_owner ? burst_cnt : '0) + BW'(1);
  assign owner_inc  = (owner_q == ID_WIDTH'(N_REQ - 1)) ?
                      '0 : owner_q + ID_WIDTH'(1);
`endif

  // Output hold register, owner and round-robin pointer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      hold_vld  <= 1'b0;
      hold_data <= '0;
      owner_q   <= '0;
      ptr_q     <= '0;
`ifdef ARB_BURST_EN
      burst_cnt <= '0;
`endif
    end else if (load) begin
      hold_vld  <= 1'b1;
      hold_data <= slice[pick_idx];
      owner_q   <= pick_idx;
`ifdef ARB_BURST_EN
      if (cnt_nxt == BW'(MAX_BURST)) begin
        ptr_q     <= idx_inc;
        burst_cnt <= '0;
      end else begin
        ptr_q     <= pick_idx;
        burst_cnt <= cnt_nxt;
      end
`else
      ptr_q <= idx_inc;
`endif
    end else begin
      if (W_INC) hold_vld <= 1'b0;
`ifdef ARB_BURST_EN
      if (burst_cnt != '0 && !REQ[owner_q]) begin
        ptr_q     <= owner_inc;
        burst_cnt <= '0;
      end
`endif
    end
  end

endmodule
